// File: rtl/sprite_cmd_sink.sv
// Sprite command sink: double-buffered (x, y, frame) command register committed on
// frame start, plus a two-stage raster pipeline producing hit flag and sprite memory address.
module sprite_cmd_sink #(
  parameter int SPRITE_FRAME_WIDTH  = 192,
  parameter int SPRITE_FRAME_HEIGHT = 128,
  parameter int NUM_FRAMES          = 5,
  localparam int AW = $clog2(SPRITE_FRAME_WIDTH * SPRITE_FRAME_HEIGHT * NUM_FRAMES)
) (
  input  logic          clk_pixel,
  input  logic          sys_rst,
  input  logic          sprite_valid,
  input  logic [10:0]   sprite_x,
  input  logic [9:0]    sprite_y,
  input  logic [2:0]    sprite_frame_number,
  output logic          sprite_ready,
  input  logic          new_frame,
  input  logic [10:0]   hcount,
  input  logic [9:0]    vcount,
  input  logic          active_draw,
  output logic          in_sprite,
  output logic [AW-1:0] pix_addr,
  output logic          ad_out,
  output logic          cmd_err
);

  localparam logic [11:0]   WIDTH_12   = 12'(SPRITE_FRAME_WIDTH);
  localparam logic [10:0]   HEIGHT_11  = 11'(SPRITE_FRAME_HEIGHT);
  localparam logic [3:0]    NUM_FR_4   = 4'(NUM_FRAMES);
  localparam logic [2:0]    LAST_FRAME = 3'(NUM_FRAMES - 1);
  localparam logic [AW-1:0] FRAME_PIX  = AW'(SPRITE_FRAME_WIDTH * SPRITE_FRAME_HEIGHT);
  localparam logic [AW-1:0] ROW_PIX    = AW'(SPRITE_FRAME_WIDTH);

  typedef enum logic {EMPTY, HELD} state_t;

  state_t      state, state_next;
  logic        transfer, frame_bad;
  logic [2:0]  frame_clamped;
  logic        load_shadow, load_active_shadow, load_active_direct;

  logic [10:0] shadow_x, active_x;
  logic [9:0]  shadow_y, active_y;
  logic [2:0]  shadow_frame, active_frame;
  logic        shadow_full, active_valid;

  assign transfer      = sprite_valid && sprite_ready;
  assign frame_bad     = ({1'b0, sprite_frame_number} >= NUM_FR_4);
  assign frame_clamped = frame_bad ? LAST_FRAME : sprite_frame_number;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_next         = state;
    load_shadow        = 1'b0;
    load_active_shadow = 1'b0;
    load_active_direct = 1'b0;
    case (state)
      EMPTY: begin
        if (transfer) begin
          if (new_frame) begin
            load_active_direct = 1'b1;
          end else begin
            load_shadow = 1'b1;
            state_next  = HELD;
          end
        end
      end
      HELD: begin
        if (new_frame) begin
          load_active_shadow = 1'b1;
          state_next         = EMPTY;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk_pixel or posedge sys_rst) begin
    if (sys_rst) begin
      state        <= EMPTY;
      sprite_ready <= 1'b0;
      cmd_err      <= 1'b0;
      shadow_x     <= '0;
      shadow_y     <= '0;
      shadow_frame <= '0;
      shadow_full  <= 1'b0;
      active_x     <= '0;
      active_y     <= '0;
      active_frame <= '0;
      active_valid <= 1'b0;
    end else begin
      state        <= state_next;
      sprite_ready <= (state_next == EMPTY);
      cmd_err      <= transfer && frame_bad;
      if (load_shadow) begin
        shadow_x     <= sprite_x;
        shadow_y     <= sprite_y;
        shadow_frame <= frame_clamped;
        shadow_full  <= 1'b1;
      end else if (load_active_shadow) begin
        shadow_full  <= 1'b0;
      end
      if (load_active_direct) begin
        active_x     <= sprite_x;
        active_y     <= sprite_y;
        active_frame <= frame_clamped;
        active_valid <= 1'b1;
      end else if (load_active_shadow) begin
        active_x     <= shadow_x;
        active_y     <= shadow_y;
        active_frame <= shadow_frame;
        active_valid <= shadow_full;
      end
    end
  end

  // Bounds are one bit wider than the raster counters so a sprite near the right/bottom edge cannot wrap.
  logic [11:0] x_end;
  logic [10:0] y_end;
  logic        hit_c;

  assign x_end = {1'b0, active_x} + WIDTH_12;
  assign y_end = {1'b0, active_y} + HEIGHT_11;
  assign hit_c = active_draw && active_valid
              && (hcount >= active_x) && ({1'b0, hcount} < x_end)
              && (vcount >= active_y) && ({1'b0, vcount} < y_end);

  logic [10:0] s1_dx;
  logic [9:0]  s1_dy;
  logic [2:0]  s1_frame;
  logic        s1_hit, s1_ad;

  always_ff @(posedge clk_pixel or posedge sys_rst) begin
    if (sys_rst) begin
      s1_dx     <= '0;
      s1_dy     <= '0;
      s1_frame  <= '0;
      s1_hit    <= 1'b0;
      s1_ad     <= 1'b0;
      in_sprite <= 1'b0;
      pix_addr  <= '0;
      ad_out    <= 1'b0;
    end else begin
      s1_dx     <= hcount - active_x;
      s1_dy     <= vcount - active_y;
      s1_frame  <= active_frame;
      s1_hit    <= hit_c;
      s1_ad     <= active_draw;
      in_sprite <= s1_hit;
      ad_out    <= s1_ad;
      pix_addr  <= s1_hit ? (AW'(s1_frame) * FRAME_PIX + AW'(s1_dy) * ROW_PIX + AW'(s1_dx))
                          : '0;
    end
  end

endmodule

// File: tb/tb_sprite_cmd_sink.sv
// Directed testbench for sprite_cmd_sink: handshake/double-buffer behaviour,
// pipeline geometry and addressing, frame clamping and reset discard.
module tb_sprite_cmd_sink;
  localparam int W  = 192;
  localparam int H  = 128;
  localparam int NF = 5;
  localparam int AW = $clog2(W * H * NF);

  logic          clk_pixel = 1'b0;
  logic          sys_rst   = 1'b1;
  logic          sprite_valid = 1'b0;
  logic [10:0]   sprite_x = '0;
  logic [9:0]    sprite_y = '0;
  logic [2:0]    sprite_frame_number = '0;
  logic          sprite_ready;
  logic          new_frame = 1'b0;
  logic [10:0]   hcount = '0;
  logic [9:0]    vcount = '0;
  logic          active_draw = 1'b0;
  logic          in_sprite;
  logic [AW-1:0] pix_addr;
  logic          ad_out;
  logic          cmd_err;

  int n_cmp = 0;
  int n_bad = 0;

  sprite_cmd_sink #(
    .SPRITE_FRAME_WIDTH (W),
    .SPRITE_FRAME_HEIGHT(H),
    .NUM_FRAMES         (NF)
  ) dut (
    .clk_pixel          (clk_pixel),
    .sys_rst            (sys_rst),
    .sprite_valid       (sprite_valid),
    .sprite_x           (sprite_x),
    .sprite_y           (sprite_y),
    .sprite_frame_number(sprite_frame_number),
    .sprite_ready       (sprite_ready),
    .new_frame          (new_frame),
    .hcount             (hcount),
    .vcount             (vcount),
    .active_draw        (active_draw),
    .in_sprite          (in_sprite),
    .pix_addr           (pix_addr),
    .ad_out             (ad_out),
    .cmd_err            (cmd_err)
  );

  always #5 clk_pixel = ~clk_pixel;

  task automatic step();
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic pulse_new_frame();
    new_frame = 1'b1;
    step();
    new_frame = 1'b0;
  endtask

  task automatic offer(input int x, input int y, input int f);
    sprite_valid        = 1'b1;
    sprite_x            = 11'(x);
    sprite_y            = 10'(y);
    sprite_frame_number = 3'(f);
  endtask

  // Presents one active pixel, then returns the pipeline result two edges later.
  task automatic probe(input int h, input int v, output logic hit, output logic [AW-1:0] addr);
    hcount      = 11'(h);
    vcount      = 10'(v);
    active_draw = 1'b1;
    step();
    active_draw = 1'b0;
    hcount      = '0;
    vcount      = '0;
    step();
    hit  = in_sprite;
    addr = pix_addr;
  endtask

  task automatic test_reset();
    step();
    step();
    n_cmp++;
    if ({sprite_ready, in_sprite, pix_addr, ad_out, cmd_err} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: ready=%b in=%b addr=%0d ad=%b err=%b, want all 0",
               sprite_ready, in_sprite, pix_addr, ad_out, cmd_err);
    end
    sys_rst = 1'b0;
    #1;
    n_cmp++;
    if (sprite_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release_ready_early: ready=%b want 0", sprite_ready);
    end
    step();
    n_cmp++;
    if (sprite_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_release_ready: ready=%b want 1", sprite_ready);
    end
  endtask

  task automatic test_basic();
    int   ph [6] = '{100, 99, 291, 292, 291, 150};
    int   pv [6] = '{200, 200, 327, 327, 328, 199};
    logic eh [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    int   ea [6] = '{49152, 0, 73727, 0, 0, 0};
    logic hit;
    logic [AW-1:0] addr;
    offer(100, 200, 2);
    step();
    sprite_valid = 1'b0;
    n_cmp++;
    if (sprite_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_ready_after_transfer: ready=%b want 0", sprite_ready);
    end
    step();
    n_cmp++;
    if (in_sprite !== 1'b0 || sprite_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_held: in=%b ready=%b want 0/0", in_sprite, sprite_ready);
    end
    pulse_new_frame();
    n_cmp++;
    if (sprite_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_ready_after_new_frame: ready=%b want 1", sprite_ready);
    end
    for (int i = 0; i < 6; i++) begin
      probe(ph[i], pv[i], hit, addr);
      n_cmp++;
      if (hit !== eh[i] || addr !== AW'(ea[i])) begin
        n_bad++;
        $display("FAIL basic_pixel[%0d] (%0d,%0d): in=%b addr=%0d want %b/%0d",
                 i, ph[i], pv[i], hit, addr, eh[i], ea[i]);
      end
    end
  endtask

  task automatic test_pipeline();
    int   ph [5] = '{100, 101, 102, 50, 103};
    int   pv [5] = '{200, 200, 201, 50, 200};
    logic pa [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic eh [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    int   ea [5] = '{49152, 49153, 49346, 0, 0};
    for (int i = 0; i <= 5; i++) begin
      if (i < 5) begin
        hcount      = 11'(ph[i]);
        vcount      = 10'(pv[i]);
        active_draw = pa[i];
      end else begin
        hcount      = '0;
        vcount      = '0;
        active_draw = 1'b0;
      end
      step();
      if (i >= 1) begin
        n_cmp++;
        if (in_sprite !== eh[i-1] || pix_addr !== AW'(ea[i-1]) || ad_out !== pa[i-1]) begin
          n_bad++;
          $display("FAIL pipeline[%0d]: in=%b addr=%0d ad=%b want %b/%0d/%b",
                   i - 1, in_sprite, pix_addr, ad_out, eh[i-1], ea[i-1], pa[i-1]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic hit;
    logic [AW-1:0] addr;
    offer(300, 100, 0);
    step();
    offer(400, 300, 3);
    step();
    step();
    n_cmp++;
    if (sprite_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_stall: ready=%b want 0", sprite_ready);
    end
    pulse_new_frame();
    n_cmp++;
    if (sprite_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_ready_after_new_frame: ready=%b want 1", sprite_ready);
    end
    step();
    sprite_valid = 1'b0;
    n_cmp++;
    if (sprite_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_second_accept: ready=%b want 0", sprite_ready);
    end
    probe(301, 101, hit, addr);
    n_cmp++;
    if (hit !== 1'b1 || addr !== AW'(193)) begin
      n_bad++;
      $display("FAIL b2b_first_active: in=%b addr=%0d want 1/193", hit, addr);
    end
    probe(400, 300, hit, addr);
    n_cmp++;
    if (hit !== 1'b0 || addr !== AW'(0)) begin
      n_bad++;
      $display("FAIL b2b_second_not_yet: in=%b addr=%0d want 0/0", hit, addr);
    end
    pulse_new_frame();
    probe(400, 300, hit, addr);
    n_cmp++;
    if (hit !== 1'b1 || addr !== AW'(73728)) begin
      n_bad++;
      $display("FAIL b2b_second_active: in=%b addr=%0d want 1/73728", hit, addr);
    end
    probe(591, 427, hit, addr);
    n_cmp++;
    if (hit !== 1'b1 || addr !== AW'(98303)) begin
      n_bad++;
      $display("FAIL b2b_second_corner: in=%b addr=%0d want 1/98303", hit, addr);
    end
  endtask

  task automatic test_same_cycle();
    int   ph [3] = '{10, 20, 9};
    int   pv [3] = '{10, 15, 10};
    logic eh [3] = '{1'b1, 1'b1, 1'b0};
    int   ea [3] = '{24576, 25546, 0};
    logic hit;
    logic [AW-1:0] addr;
    offer(10, 10, 1);
    new_frame = 1'b1;
    step();
    new_frame    = 1'b0;
    sprite_valid = 1'b0;
    n_cmp++;
    if (sprite_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL same_cycle_ready: ready=%b want 1", sprite_ready);
    end
    for (int i = 0; i < 3; i++) begin
      probe(ph[i], pv[i], hit, addr);
      n_cmp++;
      if (hit !== eh[i] || addr !== AW'(ea[i])) begin
        n_bad++;
        $display("FAIL same_cycle_pixel[%0d]: in=%b addr=%0d want %b/%0d",
                 i, hit, addr, eh[i], ea[i]);
      end
    end
    pulse_new_frame();
    probe(10, 10, hit, addr);
    n_cmp++;
    if (hit !== 1'b1 || addr !== AW'(24576)) begin
      n_bad++;
      $display("FAIL keep_last_sprite: in=%b addr=%0d want 1/24576", hit, addr);
    end
  endtask

  task automatic test_clamp();
    int   ph [4] = '{1200, 1279, 1199, 0};
    int   pv [4] = '{0, 5, 0, 0};
    logic eh [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    int   ea [4] = '{98304, 99343, 0, 0};
    logic hit;
    logic [AW-1:0] addr;
    offer(1200, 0, 7);
    step();
    sprite_valid = 1'b0;
    n_cmp++;
    if (cmd_err !== 1'b1) begin
      n_bad++;
      $display("FAIL clamp_err_pulse: cmd_err=%b want 1", cmd_err);
    end
    step();
    n_cmp++;
    if (cmd_err !== 1'b0) begin
      n_bad++;
      $display("FAIL clamp_err_one_cycle: cmd_err=%b want 0", cmd_err);
    end
    pulse_new_frame();
    for (int i = 0; i < 4; i++) begin
      probe(ph[i], pv[i], hit, addr);
      n_cmp++;
      if (hit !== eh[i] || addr !== AW'(ea[i])) begin
        n_bad++;
        $display("FAIL clamp_pixel[%0d] (%0d,%0d): in=%b addr=%0d want %b/%0d",
                 i, ph[i], pv[i], hit, addr, eh[i], ea[i]);
      end
    end
    offer(1200, 0, 5);
    step();
    sprite_valid = 1'b0;
    n_cmp++;
    if (cmd_err !== 1'b1) begin
      n_bad++;
      $display("FAIL clamp_boundary_err: cmd_err=%b want 1", cmd_err);
    end
    pulse_new_frame();
    probe(1200, 1, hit, addr);
    n_cmp++;
    if (hit !== 1'b1 || addr !== AW'(98496)) begin
      n_bad++;
      $display("FAIL clamp_boundary_addr: in=%b addr=%0d want 1/98496", hit, addr);
    end
  endtask

  task automatic test_reset_mid();
    logic hit;
    logic [AW-1:0] addr;
    offer(10, 10, 0);
    step();
    sprite_valid = 1'b0;
    sys_rst = 1'b1;
    #1;
    n_cmp++;
    if (sprite_ready !== 1'b0 || in_sprite !== 1'b0 || cmd_err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_async: ready=%b in=%b err=%b want 0/0/0",
               sprite_ready, in_sprite, cmd_err);
    end
    step();
    step();
    sys_rst = 1'b0;
    step();
    n_cmp++;
    if (sprite_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_mid_ready: ready=%b want 1", sprite_ready);
    end
    pulse_new_frame();
    probe(1200, 0, hit, addr);
    n_cmp++;
    if (hit !== 1'b0 || addr !== AW'(0)) begin
      n_bad++;
      $display("FAIL reset_mid_active_discarded: in=%b addr=%0d want 0/0", hit, addr);
    end
    probe(10, 10, hit, addr);
    n_cmp++;
    if (hit !== 1'b0 || addr !== AW'(0)) begin
      n_bad++;
      $display("FAIL reset_mid_shadow_discarded: in=%b addr=%0d want 0/0", hit, addr);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pipeline();
    test_back_to_back();
    test_same_cycle();
    test_clamp();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sprite_cmd_sink.md
SPRITE_CMD_SINK -- requirements
Module: sprite_cmd_sink

Interface
REQ-001 SPRITE_FRAME_WIDTH, default 192, sprite frame width in pixels.
REQ-002 SPRITE_FRAME_HEIGHT, default 128, sprite frame height in pixels.
REQ-003 NUM_FRAMES, default 5, number of animation frames stored back to back in sprite memory.
REQ-004 clk_pixel  in  1  pixel clock; sole clock; all logic on rising edge.
REQ-005 sys_rst  in  1  reset; asynchronous, active-high.
REQ-006 sprite_valid  in  1  command offered by producer.
REQ-007 sprite_x  in  11  sprite left edge, screen column.
REQ-008 sprite_y  in  10  sprite top edge, screen row.
REQ-009 sprite_frame_number  in  3  animation frame index.
REQ-010 sprite_ready  out  1  sink can accept a command this cycle.
REQ-011 new_frame  in  1  one-cycle frame-start pulse from the video timing generator.
REQ-012 hcount  in  11 / vcount in 10 / active_draw in 1  raster position and active-region flag.
REQ-013 in_sprite  out  1  pixel two cycles ago lies inside the committed sprite.
REQ-014 pix_addr  out  AW=$clog2(W*H*NUM_FRAMES)  sprite memory address for that pixel.
REQ-015 ad_out  out  1  active_draw delayed by 2 cycles.
REQ-016 cmd_err  out  1  one-cycle pulse: accepted command had an out-of-range frame number.

Function
REQ-017 Handshake: a command transfers on any rising edge where sprite_valid && sprite_ready; the producer holds its fields stable until transfer.
REQ-018 Command path is double-buffered: a shadow register (x, y, frame, full flag) and an active register (x, y, frame, valid flag).
REQ-019 FSM states: EMPTY (shadow empty, sprite_ready=1) and HELD (shadow full, sprite_ready=0); sprite_ready is a registered output equal to (next state == EMPTY).
REQ-020 EMPTY + transfer + no new_frame -> command loads shadow, go HELD.
REQ-021 HELD + new_frame -> shadow copies to active, active valid=1, go EMPTY.
REQ-022 EMPTY + new_frame + transfer same cycle -> command loads active directly, shadow stays empty, stay EMPTY.
REQ-023 EMPTY + new_frame, no transfer -> active unchanged (last sprite keeps being drawn).
REQ-024 Frame index >= NUM_FRAMES on transfer -> stored as NUM_FRAMES-1; cmd_err pulses for the cycle after the transfer.
REQ-025 Active register changes only on the edge sampling new_frame=1; it never changes mid-frame.
REQ-026 Stage 1 registers: dx = hcount - ax, dy = vcount - ay, hit = active_draw && avalid && hcount>=ax && hcount<ax+W && vcount>=ay && vcount<ay+H; right/bottom bounds computed 1 bit wider so no wrap at screen edge.
REQ-027 Stage 2 registers: pix_addr = frame*W*H + dy*W + dx when hit, else 0; in_sprite = hit; ad_out = delayed active_draw.
REQ-028 Latency hcount/vcount/active_draw -> in_sprite/pix_addr/ad_out is exactly 2 cycles with no bubbles; one result per cycle.
REQ-029 Sprite partly off-screen (ax+W > 1280): only on-screen pixels hit; no wrap to column 0.

Reset
REQ-030 While sys_rst=1: FSM=EMPTY, shadow full=0, active valid=0, all coordinates/frame=0, sprite_ready=0, in_sprite=0, pix_addr=0, ad_out=0, cmd_err=0.
REQ-031 sprite_ready rises on the first clk_pixel edge after sys_rst deasserts.
REQ-032 Reset mid-frame or with a command held discards both shadow and active; in_sprite stays 0 until a command is committed by new_frame.

Verification
REQ-033 Reset release, drive (x=100,y=200,frame=2) with valid, pulse new_frame -> ready drops after transfer and returns after new_frame; at hcount=100,vcount=200 in_sprite=1, pix_addr=49152, 2 cycles later.
REQ-034 Pixel (291,327) -> pix_addr=2*24576+127*192+191=73727, in_sprite=1; (292,327) and (291,328) -> in_sprite=0, pix_addr=0.
REQ-035 Valid held high with two back-to-back commands, no new_frame -> first accepted, second stalls (ready=0) until new_frame, then accepted next cycle.
REQ-036 Transfer and new_frame same cycle from EMPTY (x=10,y=10,frame=1) -> drawn in that frame, ready stays 1.
REQ-037 frame=7 command -> cmd_err pulses one cycle, address uses frame 4; x=1200 -> hits only columns 1200..1279.
REQ-038 Assert sys_rst with HELD command and active sprite -> next frames in_sprite=0 everywhere, ready=1 after release.
